csr_bank: RTL and testbench
===========================

// Module: csr_bank
// PURPOSE
//  Parametrised control/status register bank for the convolution accelerator; successor to the single set-register.
//  Holds NREG registers of WIDTH bits behind a valid/ready write port and a 1-cycle registered read port.
//  Config registers are double-buffered: shadow is written by the host, active drives the datapath.
//  Shadow is copied to active on commit, deferred while the engine is busy.
//  Adds a self-clearing start bit, a W1C status register with hardware set, and irq.
// PARAMETERS
//  WIDTH        32          register width in bits (>=2)
//  NREG         8           number of registers (>=3)
//  AW           $clog2(NREG) address width (derived, do not override)
//  STAT_IDX     NREG-1      index of the W1C status register
//  SHADOW_MASK  {NREG{1'b1}} bit i=1: reg i double-buffered. Bit 0 and bit STAT_IDX are ignored; those regs are never shadowed.
// PORTS
//  clk          in   1            clock
//  rstn         in   1            async reset, active low
//  wr_valid     in   1            write request
//  wr_ready     out  1            write accept; transfer when wr_valid & wr_ready
//  wr_addr      in   AW           write register index
//  wr_data      in   WIDTH        write data
//  wr_mask      in   WIDTH        per-bit write enable (1 = update bit)
//  wr_err       out  1            1-cycle pulse: accepted write had addr >= NREG
//  rd_en        in   1            read request
//  rd_addr      in   AW           read register index
//  rd_data      out  WIDTH        read data, valid with rd_valid
//  rd_valid     out  1            1 cycle after rd_en
//  busy         in   1            engine running; commit deferred while high
//  commit_req   in   1            request shadow->active copy (pulse)
//  commit_done  out  1            1-cycle pulse on the cycle after the copy edge
//  hw_stat_set  in   WIDTH        per-bit set strobes into the status register
//  cfg_out      out  NREG*WIDTH   active values, reg i at [i*WIDTH +: WIDTH]
//  start_pulse  out  1            1-cycle pulse when CTRL bit0 is written 1
//  irq          out  1            |status, registered
// BEHAVIOUR
//  - Reset: all shadow, active and status regs are 0, and commit_pending=0.
//    Output reset values: rd_data=0, rd_valid=0, wr_err=0, commit_done=0, start_pulse=0, irq=0, wr_ready=1.
//  - wr_ready = ~commit_pending (combinational).
//    Writes stall while a deferred commit is outstanding, so the shadow is frozen.
//  - Accepted write to reg i: new = (old & ~wr_mask) | (wr_data & wr_mask).
//    Shadowed i: updates shadow only. Non-shadowed config i: updates active, visible on cfg_out next cycle.
//  - CTRL (reg 0): bit0 is self-clearing. A write with mask[0]&data[0] gives start_pulse=1 next cycle.
//    Bit0 always reads/drives 0. Other CTRL bits behave as normal non-shadowed bits.
//  - STATUS (STAT_IDX): bit b clears when written with data[b]&mask[b]=1; data 0 has no effect.
//    hw_stat_set[b]=1 sets bit b. Simultaneous set and W1C on the same bit: set wins.
//    cfg_out slice for STAT_IDX = status; irq = |status, one cycle later.
//  - Commit:
//    - commit_req & ~busy & ~commit_pending: copy all shadowed regs to active at this edge.
//    - commit_req & busy: commit_pending<=1. The copy happens at the first edge with busy=0, then commit_pending<=0.
//    - commit_req while pending: absorbed, no second copy.
//    - commit_done pulses one cycle after each copy.
//    - Write accepted on the same edge as the copy: active takes the pre-write shadow, shadow takes the new data.
//  - Read: rd_data is registered, valid one cycle after rd_en.
//    Shadowed regs return shadow; others return active/status; addr >= NREG returns 0.
//    Read and write of the same reg on the same edge return the pre-write value.
//  - Out-of-range write: accepted, no state change, wr_err=1 next cycle.
//  - rstn asserted mid-operation: pending commit is dropped, all state returns to reset values.
// STRUCTURE
//  - Package conv_csr_pkg holds:
//    - CSR_CTRL_IDX=0, CTRL_START_BIT=0
//    - default STAT_IDX and the per-accelerator register index constants (conv size, stride, base addrs)
//    - the cfg_out slice helper function
//  - Sub-module csr_cell(WIDTH, SHADOWED): one register with masked write, optional shadow stage and commit input.
//    Generated NREG-2 times for the config regs. CTRL, STATUS and the commit FSM stay in csr_bank.
//  - Commit FSM: IDLE(pending=0) -> PEND on commit_req&busy; PEND -> IDLE on ~busy (copy).
// TESTING
//  - Reset: rstn=0 then 1 -> cfg_out=0, wr_ready=1, irq=0; reading every reg returns 0.
//  - Shadow write: wr reg1=0xDEADBEEF, mask all 1s -> cfg_out[1]=0; read reg1=0xDEADBEEF.
//    commit_req, busy=0 -> cfg_out[1]=0xDEADBEEF and commit_done one cycle after the copy edge.
//  - Deferred commit: busy=1, commit_req -> wr_ready=0, and a held write stalls; cfg_out[1] is unchanged for 10 cycles.
//    busy=0 -> copy, then wr_ready=1 and the held write completes.
//  - Masked write: reg2=0xFFFF0000, then wr 0x0000FFFF with mask 0x00FF00FF -> read reg2=0xFF0000FF.
//  - CTRL/STATUS:
//    - wr reg0 data=1 -> exactly one start_pulse; read reg0 bit0=0.
//    - hw_stat_set=0x5 -> irq=1.
//    - W1C 0x1 with simultaneous hw_stat_set=0x1 -> status stays 0x5.
//    - W1C 0x5 -> status 0, irq=0.
//  - Out-of-range (NREG=6): wr addr 7 -> wr_err pulse, no cfg_out change; read addr 7 -> rd_data=0.

Source files
------------

// File: rtl/conv_csr_pkg.sv
// ---------------------------------------------------------------------------
// conv_csr_pkg
//   Shared constants and helpers for the convolution accelerator CSR bank.
//   Ports: none (package).
//   Contents:
//     - CTRL register index and start bit position
//     - default register count / status index
//     - per-accelerator register index map
//     - commit FSM state type
//     - cfg_out slice helper
// ---------------------------------------------------------------------------
package conv_csr_pkg;

    localparam int CSR_CTRL_IDX         = 0;
    localparam int CTRL_START_BIT       = 0;

    localparam int CSR_DEFAULT_NREG     = 8;
    localparam int CSR_DEFAULT_STAT_IDX = CSR_DEFAULT_NREG - 1;

    // Register map of the convolution engine
    localparam int CSR_CONV_SIZE_IDX    = 1;
    localparam int CSR_STRIDE_IDX       = 2;
    localparam int CSR_IFM_BASE_IDX     = 3;
    localparam int CSR_WGT_BASE_IDX     = 4;
    localparam int CSR_OFM_BASE_IDX     = 5;
    localparam int CSR_PAD_IDX          = 6;

    typedef enum logic {
        COMMIT_IDLE = 1'b0,
        COMMIT_PEND = 1'b1
    } commit_state_e;

    // LSB position of register idx inside the flattened cfg_out bus
    function automatic int cfg_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/csr_cell.sv
// ---------------------------------------------------------------------------
// csr_cell
//   One configuration register with per-bit masked write and an optional
//   shadow stage. When shadowed, host writes land in the shadow and are
//   copied to the active value on commit; otherwise writes go straight to
//   the active value.
//   Ports:
//     clk, rstn       clock, async active-low reset
//     wr_en           accepted write targeting this register
//     wr_data/wr_mask write data and per-bit enable
//     commit          copy shadow -> active at this edge (shadowed only)
//     rd_value        host-visible value (shadow if shadowed, else active)
//     active          value driving the datapath
// ---------------------------------------------------------------------------
module csr_cell
    import conv_csr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SHADOWED = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             commit,
    output logic [WIDTH-1:0] rd_value,
    output logic [WIDTH-1:0] active
);

    if (SHADOWED) begin : g_shadow
        logic [WIDTH-1:0] shadow_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                shadow_q <= '0;
            end else if (wr_en) begin
                shadow_q <= (shadow_q & ~wr_mask) | (wr_data & wr_mask);
            end
        end

        // Copy samples the pre-write shadow when a write lands on the same edge
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                active <= '0;
            end else if (commit) begin
                active <= shadow_q;
            end
        end

        assign rd_value = shadow_q;
    end else begin : g_direct
        logic unused_commit;
        assign unused_commit = commit;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                active <= '0;
            end else if (wr_en) begin
                active <= (active & ~wr_mask) | (wr_data & wr_mask);
            end
        end

        assign rd_value = active;
    end

endmodule

// File: rtl/csr_bank.sv
// ---------------------------------------------------------------------------
// csr_bank
//   Control/status register bank for the convolution accelerator.
//   Reg 0 is CTRL (bit0 self-clearing start), reg STAT_IDX is a W1C status
//   register with hardware set, all other regs are config cells that are
//   double-buffered where SHADOW_MASK selects it.
//   Ports:
//     clk, rstn                      clock, async active-low reset
//     wr_valid/wr_ready              write handshake (stalls while commit pending)
//     wr_addr/wr_data/wr_mask        write index, data, per-bit enable
//     wr_err                         pulse: accepted write was out of range
//     rd_en/rd_addr                  read request
//     rd_data/rd_valid               registered read response
//     busy                           engine running, defers commit
//     commit_req/commit_done         shadow->active copy request / done pulse
//     hw_stat_set                    per-bit status set strobes
//     cfg_out                        active values, reg i at [i*WIDTH +: WIDTH]
//     start_pulse                    pulse when CTRL bit0 written 1
//     irq                            registered OR of status
//
//   Commit FSM
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   COMMIT_IDLE  | no commit outstanding, writes accepted
//   COMMIT_PEND  | commit requested while busy, waiting for busy=0, writes stall
// ---------------------------------------------------------------------------
module csr_bank
    import conv_csr_pkg::*;
#(
    parameter int              WIDTH       = 32,
    parameter int              NREG        = 8,
    parameter int              STAT_IDX    = NREG - 1,
    parameter logic [NREG-1:0] SHADOW_MASK = {NREG{1'b1}},
    localparam int             AW          = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH-1:0]      wr_mask,
    output logic                  wr_err,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  busy,
    input  logic                  commit_req,
    output logic                  commit_done,
    input  logic [WIDTH-1:0]      hw_stat_set,
    output logic [NREG*WIDTH-1:0] cfg_out,
    output logic                  start_pulse,
    output logic                  irq
);

    localparam logic [WIDTH-1:0] CTRL_SELF_CLR = WIDTH'(1) << CTRL_START_BIT;

    commit_state_e    state_q;
    commit_state_e    state_d;
    logic             commit_copy;

    logic             wr_fire;
    logic             wr_in_range;
    logic [NREG-1:0]  wr_sel;

    logic [WIDTH-1:0] ctrl_q;
    logic [WIDTH-1:0] stat_q;
    logic [WIDTH-1:0] stat_w1c;

    logic [WIDTH-1:0] rd_vals  [NREG];
    logic [WIDTH-1:0] act_vals [NREG];
    logic [WIDTH-1:0] rd_mux;

    // ---------------- write decode ----------------
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = int'(wr_addr) < NREG;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_sel[i] = wr_fire && wr_in_range && (int'(wr_addr) == i);
        end
    end

    // ---------------- commit FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= COMMIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COMMIT_IDLE: if (commit_req && busy) state_d = COMMIT_PEND;
            COMMIT_PEND: if (!busy)              state_d = COMMIT_IDLE;
            default:                             state_d = COMMIT_IDLE;
        endcase
    end

    // Requests arriving while pending are absorbed: PEND copies only on ~busy
    always_comb begin
        commit_copy = 1'b0;
        wr_ready    = 1'b1;
        case (state_q)
            COMMIT_IDLE: commit_copy = commit_req & ~busy;
            COMMIT_PEND: begin
                commit_copy = ~busy;
                wr_ready    = 1'b0;
            end
            default: begin
                commit_copy = 1'b0;
                wr_ready    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            commit_done <= 1'b0;
        end else begin
            commit_done <= commit_copy;
        end
    end

    // ---------------- register array ----------------
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == CSR_CTRL_IDX) begin : g_ctrl
            assign rd_vals[i]  = ctrl_q;
            assign act_vals[i] = ctrl_q;
        end else if (i == STAT_IDX) begin : g_stat
            assign rd_vals[i]  = stat_q;
            assign act_vals[i] = stat_q;
        end else begin : g_cfg
            csr_cell #(
                .WIDTH    (WIDTH),
                .SHADOWED (SHADOW_MASK[i])
            ) u_cell (
                .clk      (clk),
                .rstn     (rstn),
                .wr_en    (wr_sel[i]),
                .wr_data  (wr_data),
                .wr_mask  (wr_mask),
                .commit   (commit_copy),
                .rd_value (rd_vals[i]),
                .active   (act_vals[i])
            );
        end
        assign cfg_out[cfg_lsb(i, WIDTH) +: WIDTH] = act_vals[i];
    end

    // ---------------- CTRL ----------------
    // Start bit is never stored, so it reads and drives 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q      <= '0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= wr_sel[CSR_CTRL_IDX] & wr_mask[CTRL_START_BIT]
                         & wr_data[CTRL_START_BIT];
            if (wr_sel[CSR_CTRL_IDX]) begin
                ctrl_q <= ((ctrl_q & ~wr_mask) | (wr_data & wr_mask)) & ~CTRL_SELF_CLR;
            end
        end
    end

    // ---------------- STATUS ----------------
    // Set is OR-ed after the clear so hardware set wins over W1C.
    assign stat_w1c = wr_sel[STAT_IDX] ? (wr_data & wr_mask) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_q <= '0;
            irq    <= 1'b0;
        end else begin
            stat_q <= (stat_q & ~stat_w1c) | hw_stat_set;
            irq    <= |stat_q;
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(rd_addr) == i) rd_mux = rd_vals[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
            wr_err   <= wr_fire & ~wr_in_range;
        end
    end

endmodule

// File: tb/tb_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_csr_bank
//   Directed bench for csr_bank with NREG=6 (status at 5), regs 1..3
//   shadowed and reg 4 written directly.
// ---------------------------------------------------------------------------
module tb_csr_bank;

    localparam int WIDTH = 32;
    localparam int NREG  = 6;
    localparam int AW    = 3;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      wr_mask;
    logic                  wr_err;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  commit_req;
    logic                  commit_done;
    logic [WIDTH-1:0]      hw_stat_set;
    logic [NREG*WIDTH-1:0] cfg_out;
    logic                  start_pulse;
    logic                  irq;

    int checks = 0;
    int errors = 0;

    csr_bank #(
        .WIDTH       (WIDTH),
        .NREG        (NREG),
        .STAT_IDX    (5),
        .SHADOW_MASK (6'b101110)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .wr_err      (wr_err),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .commit_req  (commit_req),
        .commit_done (commit_done),
        .hw_stat_set (hw_stat_set),
        .cfg_out     (cfg_out),
        .start_pulse (start_pulse),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NREG*WIDTH-1:0] obs,
                       input logic [NREG*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cfg(input int idx);
        return cfg_out[idx*WIDTH +: WIDTH];
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [WIDTH-1:0] v);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        v       = rd_data;
    endtask

    logic [WIDTH-1:0] v;

    initial begin
        rstn        = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_mask     = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        busy        = 1'b0;
        commit_req  = 1'b0;
        hw_stat_set = '0;
        step();
        step();
        rstn = 1'b1;
        step();

        // reset state
        chk("rst_cfg_out", cfg_out, '0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_irq", irq, 0);
        chk("rst_rd_valid", rd_valid, 0);
        for (int i = 0; i < NREG; i++) begin
            rd(AW'(i), v);
            chk($sformatf("rst_read_%0d", i), v, 0);
        end
        chk("rd_valid_after_read", rd_valid, 1);

        // shadow write then immediate commit
        wr(3'd1, 32'hDEADBEEF, 32'hFFFFFFFF);
        chk("shadow_cfg1_unchanged", cfg(1), 0);
        rd(3'd1, v);
        chk("shadow_read1", v, 32'hDEADBEEF);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("commit_done_pulse", commit_done, 1);
        chk("commit_cfg1", cfg(1), 32'hDEADBEEF);
        step();
        chk("commit_done_low", commit_done, 0);

        // deferred commit with a stalled write
        wr(3'd1, 32'h12345678, 32'hFFFFFFFF);
        busy       = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("defer_wr_ready_low", wr_ready, 0);
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 32'hAAAA5555;
        wr_mask  = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("defer_cfg1_hold_%0d", i), cfg(1), 32'hDEADBEEF);
            chk($sformatf("defer_stall_%0d", i), wr_ready, 0);
        end
        busy = 1'b0;
        step();
        chk("defer_commit_done", commit_done, 1);
        chk("defer_cfg1_copied", cfg(1), 32'h12345678);
        chk("defer_wr_ready_back", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        rd(3'd1, v);
        chk("held_write_done", v, 32'hAAAA5555);
        chk("held_write_cfg1", cfg(1), 32'h12345678);

        // masked write
        wr(3'd2, 32'hFFFF0000, 32'hFFFFFFFF);
        wr(3'd2, 32'h0000FFFF, 32'h00FF00FF);
        rd(3'd2, v);
        chk("masked_read2", v, 32'hFF0000FF);

        // non-shadowed config reg
        wr(3'd4, 32'hCAFEF00D, 32'hFFFFFFFF);
        chk("direct_cfg4", cfg(4), 32'hCAFEF00D);

        // read and write same reg on same edge
        wr_valid = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 32'h00000011;
        wr_mask  = 32'hFFFFFFFF;
        rd_en    = 1'b1;
        rd_addr  = 3'd3;
        step();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        chk("rdwr_same_edge_old", rd_data, 0);
        rd(3'd3, v);
        chk("rdwr_new_value", v, 32'h00000011);

        // write on the same edge as a copy
        commit_req = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 3'd3;
        wr_data    = 32'h00000022;
        step();
        commit_req = 1'b0;
        wr_valid   = 1'b0;
        chk("copywr_cfg3_prewrite", cfg(3), 32'h00000011);
        chk("copywr_cfg2", cfg(2), 32'hFF0000FF);
        chk("copywr_cfg1", cfg(1), 32'hAAAA5555);
        rd(3'd3, v);
        chk("copywr_shadow3", v, 32'h00000022);

        // CTRL start bit
        wr(3'd0, 32'h00000003, 32'hFFFFFFFF);
        chk("start_pulse_high", start_pulse, 1);
        chk("ctrl_cfg0", cfg(0), 32'h00000002);
        step();
        chk("start_pulse_once", start_pulse, 0);
        rd(3'd0, v);
        chk("ctrl_read0", v, 32'h00000002);

        // STATUS set / W1C
        hw_stat_set = 32'h5;
        step();
        hw_stat_set = '0;
        chk("stat_set", cfg(5), 32'h5);
        chk("irq_lag", irq, 0);
        step();
        chk("irq_high", irq, 1);
        hw_stat_set = 32'h1;
        wr(3'd5, 32'h1, 32'hFFFFFFFF);
        hw_stat_set = '0;
        chk("set_wins", cfg(5), 32'h5);
        wr(3'd5, 32'h0, 32'hFFFFFFFF);
        chk("w1c_zero_noop", cfg(5), 32'h5);
        wr(3'd5, 32'h5, 32'hFFFFFFFF);
        chk("w1c_clear", cfg(5), 32'h0);
        step();
        chk("irq_low", irq, 0);

        // out of range
        wr(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("oor_wr_err", wr_err, 1);
        chk("oor_cfg_out", cfg_out,
            {32'h0, 32'hCAFEF00D, 32'h00000011, 32'hFF0000FF, 32'hAAAA5555, 32'h00000002});
        step();
        chk("oor_wr_err_low", wr_err, 0);
        rd(3'd7, v);
        chk("oor_read", v, 0);

        // reset with a pending commit
        busy       = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("pend_before_reset", wr_ready, 0);
        rstn = 1'b0;
        #2;
        chk("mid_rst_cfg_out", cfg_out, '0);
        chk("mid_rst_wr_ready", wr_ready, 1);
        step();
        rstn = 1'b1;
        busy = 1'b0;
        step();
        chk("pend_dropped", commit_done, 0);
        step();
        chk("pend_dropped_late", commit_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
